dlf_pi_gear: RTL and testbench

DLF_PI_GEAR -- requirements
Module: dlf_pi_gear

---
 rtl/dlf_pi_gear_if.sv | 23 ++
 rtl/dlf_pi_gear.sv | 145 ++++++++++++++
 tb/tb_dlf_pi_gear.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dlf_pi_gear_if.sv
// Sample/result bundle for the gear-shifting PI loop filter.
// Handshake: the source presents err_in with err_valid high for one cycle per sample.
// There is no ready signal and no backpressure. The filter either consumes the sample
// on that edge, or drops it while in holdover. out_valid pulses once for each consumed
// sample, in the same cycle that dlf_out and dlf_int take their new values.
interface dlf_pi_gear_if #(
  parameter int ERR_W = 20,
  parameter int INT_W = 29,
  parameter int OUT_W = 16
);
  logic signed [ERR_W-1:0] err_in;
  logic                    err_valid;
  logic        [OUT_W-1:0] dlf_out;
  logic                    out_valid;
  logic signed [INT_W-1:0] dlf_int;
  logic        [1:0]       gear;
  logic                    locked;

  modport master (output err_in, err_valid,
                  input  dlf_out, out_valid, dlf_int, gear, locked);
  modport slave  (input  err_in, err_valid,
                  output dlf_out, out_valid, dlf_int, gear, locked);
endinterface

// File: rtl/dlf_pi_gear.sv
// Digital PI loop filter for a DCO.
// It has an acquire/track gear shift driven by a lock counter, plus a holdover mode.
module dlf_pi_gear #(
  parameter int ERR_W    = 20,
  parameter int INT_W    = 29,
  parameter int K_W      = 11,
  parameter int OUT_W    = 16,
  parameter int LOCK_CNT = 64
) (
  input  logic             clk,
  input  logic             rst,
  dlf_pi_gear_if.slave     s,
  input  logic             hold,
  input  logic [3:0]       beta_acq,
  input  logic [3:0]       beta_trk,
  input  logic [K_W-1:0]   k_acq,
  input  logic [K_W-1:0]   k_trk,
  input  logic [ERR_W-1:0] lock_thr,
  input  logic [OUT_W-1:0] bias
);
  localparam int SW   = INT_W + 1;
  localparam int PW   = SW + K_W + 1;
  localparam int FRAC = 16;
  localparam int TW   = ((PW > OUT_W) ? PW : OUT_W) + 1;
  localparam int CW   = $clog2(LOCK_CNT + 1);

  localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [PW-1:0]           HALF    = PW'(1) << (FRAC - 1);

  typedef enum logic [1:0] {ACQ = 2'd0, TRK = 2'd1, HOLD = 2'd2} gear_t;

  gear_t                   state;
  logic [CW-1:0]           cnt;
  logic signed [INT_W-1:0] int_q;
  logic [OUT_W-1:0]        out_q;
  logic                    valid_q;
  logic                    locked_q;

  logic signed [INT_W-1:0] err_ext;
  logic signed [SW-1:0]    sum_i;
  logic signed [INT_W-1:0] int_new;
  logic [3:0]              beta_sel;
  logic [K_W-1:0]          k_sel;
  logic signed [INT_W-1:0] shifted;
  logic signed [SW-1:0]    s_sum;
  logic signed [K_W:0]     k_ext;
  logic signed [PW-1:0]    prod;
  logic                    neg;
  logic [PW-1:0]           mag;
  logic [PW-1:0]           rnd;
  logic signed [PW-1:0]    p_int;
  logic signed [TW-1:0]    bias_ext;
  logic signed [TW-1:0]    tot;
  logic [OUT_W-1:0]        out_sat;
  logic [ERR_W-1:0]        abs_err;
  logic                    in_thr;
  logic                    over2;
  logic [CW-1:0]           cnt_inc;

  assign err_ext = INT_W'(s.err_in);
  assign sum_i   = SW'(int_q) + SW'(err_ext);

  // Integrator saturates rather than wraps; overflow shows as a mismatch of the two top bits.
  always_comb begin
    int_new = sum_i[INT_W-1:0];
    if (sum_i[INT_W] != sum_i[INT_W-1])
      int_new = sum_i[INT_W] ? INT_MIN : INT_MAX;
  end

  assign beta_sel = (state == TRK) ? beta_trk : beta_acq;
  assign k_sel    = (state == TRK) ? k_trk : k_acq;
  assign shifted  = int_new >>> beta_sel;
  assign s_sum    = SW'(err_ext) + SW'(shifted);
  assign k_ext    = signed'({1'b0, k_sel});
  assign prod     = PW'(s_sum) * PW'(k_ext);

  // Round half away from zero: round the magnitude, then restore the sign.
  assign neg   = prod[PW-1];
  assign mag   = neg ? PW'(-prod) : PW'(prod);
  assign rnd   = (mag + HALF) >> FRAC;
  assign p_int = neg ? -signed'(rnd) : signed'(rnd);

  assign bias_ext = TW'(bias);
  assign tot      = TW'(p_int) + bias_ext;

  always_comb begin
    out_sat = tot[OUT_W-1:0];
    if (tot[TW-1])
      out_sat = '0;
    else if (|tot[TW-2:OUT_W])
      out_sat = '1;
  end

  // The most negative code has magnitude 2^(ERR_W-1), which still fits unsigned in ERR_W bits.
  assign abs_err = s.err_in[ERR_W-1] ? ERR_W'(-s.err_in) : ERR_W'(s.err_in);
  assign in_thr  = (abs_err <= lock_thr);
  assign over2   = ({1'b0, abs_err} > {lock_thr, 1'b0});
  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACQ;
      cnt      <= '0;
      int_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (hold) begin
        state    <= HOLD;
        locked_q <= 1'b0;
      end else if (state == HOLD) begin
        state <= ACQ;
        cnt   <= '0;
      end else if (s.err_valid) begin
        int_q   <= int_new;
        out_q   <= out_sat;
        valid_q <= 1'b1;
        if (state == ACQ) begin
          if (!in_thr) begin
            cnt <= '0;
          end else if (cnt_inc == CW'(LOCK_CNT)) begin
            state    <= TRK;
            locked_q <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end else if (over2) begin
          state    <= ACQ;
          locked_q <= 1'b0;
          cnt      <= '0;
        end
      end
    end
  end

  assign s.dlf_out   = out_q;
  assign s.out_valid = valid_q;
  assign s.dlf_int   = int_q;
  assign s.gear      = state;
  assign s.locked    = locked_q;
endmodule

// File: tb/tb_dlf_pi_gear.sv
// Directed bench for dlf_pi_gear.
// Expected values are hand-computed from the filter equations.
module tb_dlf_pi_gear;
  localparam int ERR_W = 20;
  localparam int INT_W = 29;
  localparam int K_W   = 11;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hold = 1'b0;
  logic [3:0]       beta_acq = '0;
  logic [3:0]       beta_trk = '0;
  logic [K_W-1:0]   k_acq = '0;
  logic [K_W-1:0]   k_trk = '0;
  logic [ERR_W-1:0] lock_thr = '0;
  logic [OUT_W-1:0] bias = '0;

  int checks = 0;
  int errors = 0;

  dlf_pi_gear_if #(.ERR_W(ERR_W), .INT_W(INT_W), .OUT_W(OUT_W)) bus ();

  dlf_pi_gear #(.ERR_W(ERR_W), .INT_W(INT_W), .K_W(K_W), .OUT_W(OUT_W), .LOCK_CNT(64)) dut (
    .clk(clk), .rst(rst), .s(bus.slave), .hold(hold),
    .beta_acq(beta_acq), .beta_trk(beta_trk), .k_acq(k_acq), .k_trk(k_trk),
    .lock_thr(lock_thr), .bias(bias)
  );

  always #5 clk = ~clk;

  task automatic send(input int e);
    @(negedge clk);
    bus.err_in = ERR_W'(e);
    bus.err_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.err_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.err_in = '0;
    bus.err_valid = 1'b0;
    rst = 1'b1;
    #12;
    checks++; if (bus.dlf_out !== 16'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", bus.dlf_out); end
    checks++; if (bus.dlf_int !== 29'sd0) begin errors++; $display("FAIL reset_int: got %0d expected 0", bus.dlf_int); end
    checks++; if (bus.gear !== 2'd0 || bus.locked !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_state: got gear=%0d locked=%0b ov=%0b expected 0/0/0", bus.gear, bus.locked, bus.out_valid); end
    @(negedge clk);
    rst = 1'b0;
    bias = 16'd1000;
    idle(); idle();
    checks++; if (bus.dlf_out !== 16'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got out=%0d ov=%0b expected 0/0", bus.dlf_out, bus.out_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    beta_acq = 4'd0; k_acq = 11'd32; bias = 16'd1000; lock_thr = 20'd100;
    send(2048);
    checks++; if (bus.dlf_int !== 29'sd2048) begin errors++; $display("FAIL basic_int: got %0d expected 2048", bus.dlf_int); end
    checks++; if (bus.dlf_out !== 16'd1002) begin errors++; $display("FAIL basic_out: got %0d expected 1002", bus.dlf_out); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_ov: got %0b expected 1", bus.out_valid); end
    idle();
    checks++; if (bus.out_valid !== 1'b0 || bus.dlf_out !== 16'd1002 || bus.dlf_int !== 29'sd2048) begin
      errors++; $display("FAIL basic_idle_hold: got ov=%0b out=%0d int=%0d expected 0/1002/2048", bus.out_valid, bus.dlf_out, bus.dlf_int); end
  endtask

  task automatic test_rounding();
    int errs [6] = '{512, -512, 256, -256, 768, -768};
    int exps [6] = '{1001, 999, 1000, 1000, 1001, 999};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      beta_acq = 4'd0; k_acq = 11'd32; bias = 16'd1000;
      send(errs[i]);
      checks++; if (bus.dlf_out !== OUT_W'(exps[i])) begin
        errors++; $display("FAIL round_%0d: got %0d expected %0d", errs[i], bus.dlf_out, exps[i]); end
    end
  endtask

  task automatic test_negative();
    do_reset();
    beta_acq = 4'd0; k_acq = 11'd32; bias = 16'd10;
    send(-2048);
    checks++; if (bus.dlf_out !== 16'd8) begin errors++; $display("FAIL neg_s1: got %0d expected 8", bus.dlf_out); end
    send(-2048);
    send(-2048);
    checks++; if (bus.dlf_out !== 16'd6) begin errors++; $display("FAIL neg_s3: got %0d expected 6", bus.dlf_out); end
    for (int i = 0; i < 12; i++) send(-2048);
    checks++; if (bus.dlf_out !== 16'd0) begin errors++; $display("FAIL neg_clamp: got %0d expected 0", bus.dlf_out); end
    checks++; if (bus.dlf_int !== -29'sd30720) begin errors++; $display("FAIL neg_int: got %0d expected -30720", bus.dlf_int); end
  endtask

  task automatic test_saturation();
    bit wrapped = 1'b0;
    do_reset();
    beta_acq = 4'd0; k_acq = 11'd32; bias = 16'd1000;
    for (int i = 0; i < 600; i++) begin
      send(524287);
      if (bus.dlf_int < 0) wrapped = 1'b1;
    end
    checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL sat_nowrap: got wrapped=%0b expected 0", wrapped); end
    checks++; if (bus.dlf_int !== 29'sd268435455) begin errors++; $display("FAIL sat_int: got %0d expected 268435455", bus.dlf_int); end
    checks++; if (bus.dlf_out !== 16'd65535) begin errors++; $display("FAIL sat_out: got %0d expected 65535", bus.dlf_out); end
  endtask

  task automatic test_lock();
    do_reset();
    lock_thr = 20'd100; beta_acq = 4'd15; beta_trk = 4'd15;
    k_acq = 11'd0; k_trk = 11'd2047; bias = 16'd1000;
    for (int i = 0; i < 63; i++) send(50);
    send(150);
    for (int i = 0; i < 63; i++) send(50);
    checks++; if (bus.locked !== 1'b0 || bus.gear !== 2'd0) begin
      errors++; $display("FAIL lock_127: got locked=%0b gear=%0d expected 0/0", bus.locked, bus.gear); end
    send(50);
    checks++; if (bus.locked !== 1'b1 || bus.gear !== 2'd1) begin
      errors++; $display("FAIL lock_128: got locked=%0b gear=%0d expected 1/1", bus.locked, bus.gear); end
    checks++; if (bus.dlf_out !== 16'd1000) begin errors++; $display("FAIL lock_acq_gain: got %0d expected 1000", bus.dlf_out); end
    send(150);
    checks++; if (bus.dlf_out !== 16'd1005 || bus.gear !== 2'd1) begin
      errors++; $display("FAIL trk_gain: got out=%0d gear=%0d expected 1005/1", bus.dlf_out, bus.gear); end
    send(250);
    checks++; if (bus.dlf_out !== 16'd1008) begin errors++; $display("FAIL unlock_trk_gain: got %0d expected 1008", bus.dlf_out); end
    checks++; if (bus.gear !== 2'd0 || bus.locked !== 1'b0) begin
      errors++; $display("FAIL unlock_state: got gear=%0d locked=%0b expected 0/0", bus.gear, bus.locked); end
    send(150);
    checks++; if (bus.dlf_out !== 16'd1000) begin errors++; $display("FAIL reacq_gain: got %0d expected 1000", bus.dlf_out); end
  endtask

  task automatic test_hold();
    do_reset();
    lock_thr = 20'd100; beta_acq = 4'd0; k_acq = 11'd32; bias = 16'd1000;
    for (int i = 0; i < 40; i++) send(50);
    checks++; if (bus.dlf_int !== 29'sd2000 || bus.dlf_out !== 16'd1001) begin
      errors++; $display("FAIL hold_pre: got int=%0d out=%0d expected 2000/1001", bus.dlf_int, bus.dlf_out); end
    @(negedge clk);
    hold = 1'b1;
    bus.err_in = 20'sd50;
    bus.err_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.err_valid = 1'b0;
    checks++; if (bus.gear !== 2'd2 || bus.out_valid !== 1'b0 || bus.dlf_int !== 29'sd2000 || bus.dlf_out !== 16'd1001) begin
      errors++; $display("FAIL hold_enter: got gear=%0d ov=%0b int=%0d out=%0d expected 2/0/2000/1001",
                         bus.gear, bus.out_valid, bus.dlf_int, bus.dlf_out); end
    send(50);
    send(-3000);
    checks++; if (bus.out_valid !== 1'b0 || bus.dlf_int !== 29'sd2000 || bus.dlf_out !== 16'd1001 || bus.gear !== 2'd2) begin
      errors++; $display("FAIL hold_ignore: got ov=%0b int=%0d out=%0d gear=%0d expected 0/2000/1001/2",
                         bus.out_valid, bus.dlf_int, bus.dlf_out, bus.gear); end
    @(negedge clk);
    hold = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.gear !== 2'd0) begin errors++; $display("FAIL hold_release: got gear=%0d expected 0", bus.gear); end
    for (int i = 0; i < 63; i++) send(50);
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL hold_cnt_cleared: got locked=%0b expected 0", bus.locked); end
    send(50);
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL hold_relock: got locked=%0b expected 1", bus.locked); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.gear !== 2'd0 || bus.locked !== 1'b0 || bus.dlf_int !== 29'sd0 || bus.dlf_out !== 16'd0) begin
      errors++; $display("FAIL areset_trk: got gear=%0d locked=%0b int=%0d out=%0d expected 0/0/0/0",
                         bus.gear, bus.locked, bus.dlf_int, bus.dlf_out); end
    @(negedge clk);
    rst = 1'b0;
    send(2048);
    hold = 1'b1;
    idle();
    checks++; if (bus.gear !== 2'd2) begin errors++; $display("FAIL areset_hold_setup: got gear=%0d expected 2", bus.gear); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.gear !== 2'd0 || bus.dlf_int !== 29'sd0 || bus.dlf_out !== 16'd0) begin
      errors++; $display("FAIL areset_hold: got gear=%0d int=%0d out=%0d expected 0/0/0", bus.gear, bus.dlf_int, bus.dlf_out); end
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(); idle(); idle();
    checks++; if (bus.dlf_out !== 16'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL areset_idle: got out=%0d ov=%0b expected 0/0", bus.dlf_out, bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_negative();
    test_saturation();
    test_lock();
    test_hold();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
